// File: rtl/ber_monitor.sv
// ber_monitor
// -----------------------------------------------------------------------------
// Bit-error-rate checker for the communication chain. On each display frame
// it waits SETTLE_CYCLES after frame_tick, then samples the transmitted and
// decoded bytes. It counts the differing bits and keeps frame and error
// statistics. It also drives a 4-digit common-anode seven-segment display.
//
// Parameters:
//   SETTLE_CYCLES  clk_sys cycles from frame_tick to sampling (>= 1)
//   SCAN_DIV       clk_sys cycles per display digit (power of two, >= 2)
//   ERR_W          width of the cumulative error counter (>= 4)
//
// Ports:
//   clk_sys         system clock
//   reset           asynchronous reset, active-low
//   frame_tick      one-cycle pulse marking the start of a display frame
//   tx_byte         transmitted reference byte
//   rx_byte         decoded received byte
//   sample_valid    one-cycle pulse while the statistics are updating
//   frame_err_bits  bit errors found in the last compared frame (0..8)
//   frame_cnt       number of compared frames, wraps at 2^16
//   err_total       cumulative bit errors, saturates at 2^ERR_W-1
//   err_flag        sticky, set once any frame has shown a bit error
//   seg             segments {g,f,e,d,c,b,a}, active-low
//   an              digit enables, active-low one-hot
//
// Build option:
//   BER_MON_ERRDISP_EN  when defined, digits 0-1 show err_total[7:0] and
//                       digits 2-3 show frame_cnt[7:0]. A saturated
//                       err_total shows "FFFF". When undefined, digits 0-1
//                       show the sampled TX byte and digits 2-3 show the
//                       sampled RX byte.
// -----------------------------------------------------------------------------
module ber_monitor #(
    parameter int SETTLE_CYCLES = 1024,
    parameter int SCAN_DIV      = 65536,
    parameter int ERR_W         = 20
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [7:0]       tx_byte,
    input  logic [7:0]       rx_byte,
    output logic             sample_valid,
    output logic [3:0]       frame_err_bits,
    output logic [15:0]      frame_cnt,
    output logic [ERR_W-1:0] err_total,
    output logic             err_flag,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CMP, UPD} state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    state_t             r_state;
    logic [SET_W-1:0]   r_settle;
    logic [7:0]         r_tx_s;
    logic [7:0]         r_rx_s;
    logic [3:0]         r_pop;
    logic               r_sample_valid;
    logic [3:0]         r_frame_err_bits;
    logic [15:0]        r_frame_cnt;
    logic [ERR_W-1:0]   r_err_total;
    logic               r_err_flag;
    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]         r_digit;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    // Widen by one bit so the carry shows an overflow. pop is at most 8,
    // so a single add can never step past the clamp value twice.
    logic [ERR_W:0]     w_err_sum;
    logic [ERR_W-1:0]   w_err_next;
    logic               w_wrap;
    logic [1:0]         w_digit_nxt;
    logic [3:0]         w_nib;

    assign w_err_sum  = {1'b0, r_err_total} + (ERR_W+1)'(r_pop);
    assign w_err_next = w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];

    // Statistics FSM
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_settle         <= '0;
            r_tx_s           <= '0;
            r_rx_s           <= '0;
            r_pop            <= '0;
            r_sample_valid   <= 1'b0;
            r_frame_err_bits <= '0;
            r_frame_cnt      <= '0;
            r_err_total      <= '0;
            r_err_flag       <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_tick) begin
                        r_settle <= SET_LOAD;
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    // A new tick restarts the frame; the old one is dropped.
                    if (frame_tick) begin
                        r_settle <= SET_LOAD;
                    end else if (r_settle == '0) begin
                        r_state <= CMP;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                CMP: begin
                    r_tx_s         <= tx_byte;
                    r_rx_s         <= rx_byte;
                    r_pop          <= popcount8(tx_byte ^ rx_byte);
                    r_sample_valid <= 1'b1;
                    r_state        <= UPD;
                end
                default: begin
                    r_frame_err_bits <= r_pop;
                    r_frame_cnt      <= r_frame_cnt + 16'd1;
                    r_err_total      <= w_err_next;
                    r_err_flag       <= r_err_flag | (r_pop != 4'd0);
                    r_state          <= IDLE;
                end
            endcase
        end
    end

    // Display scan: the digit index, an and seg all move on the same edge,
    // so seg always shows the glyph of the digit that an is enabling.
    assign w_wrap      = &r_scan_cnt;
    assign w_digit_nxt = r_digit + {1'b0, w_wrap};

`ifdef BER_MON_ERRDISP_EN
    logic [7:0] w_err_lo;
    assign w_err_lo = 8'(r_err_total);

    always_comb begin
        w_nib = 4'h0;
        case (w_digit_nxt)
            2'd0: w_nib = w_err_lo[7:4];
            2'd1: w_nib = w_err_lo[3:0];
            2'd2: w_nib = r_frame_cnt[7:4];
            default: w_nib = r_frame_cnt[3:0];
        endcase
        if (&r_err_total) w_nib = 4'hF;
    end
`else
    always_comb begin
        w_nib = 4'h0;
        case (w_digit_nxt)
            2'd0: w_nib = r_tx_s[7:4];
            2'd1: w_nib = r_tx_s[3:0];
            2'd2: w_nib = r_rx_s[7:4];
            default: w_nib = r_rx_s[3:0];
        endcase
    end
`endif

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
            r_an       <= 4'b1110;
            r_seg      <= 7'h7F;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
            r_digit    <= w_digit_nxt;
            r_an       <= ~(4'b0001 << w_digit_nxt);
            r_seg      <= hex7(w_nib);
        end
    end

    assign sample_valid   = r_sample_valid;
    assign frame_err_bits = r_frame_err_bits;
    assign frame_cnt      = r_frame_cnt;
    assign err_total      = r_err_total;
    assign err_flag       = r_err_flag;
    assign seg            = r_seg;
    assign an             = r_an;

endmodule
